// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: 8N1 UART transmitter FSM with ready/valid byte handoff and frame counter
// Ports: i_Clk clock; i_Rst_n async active-low reset; i_Tx_DV/i_Tx_Byte byte request, taken
// when o_Tx_Ready; current_state/bit_index expose the FSM; o_Tx_Byte held byte; o_Tx_Serial line;
// o_Tx_Active start..stop; o_Tx_Done one-cycle cleanup pulse; o_Frame_Count completed frames mod 256.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic [2:0] current_state,
    output logic [2:0] bit_index,
    output logic [7:0] o_Tx_Byte,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done,
    output logic [7:0] o_Frame_Count
);
    typedef enum logic [2:0] {
        s_IDLE         = 3'd0,
        s_TX_START_BIT = 3'd1,
        s_TX_DATA_BITS = 3'd2,
        s_TX_STOP_BIT  = 3'd3,
        s_CLEANUP      = 3'd4
    } state_t;
    localparam logic [11:0] LAST = 12'(CLKS_PER_BIT - 1);
    state_t      state_q, state_d;
    logic [11:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_index_q, bit_index_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        bit_end;
    assign bit_end = clk_count_q == LAST;
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q       <= s_IDLE;
            clk_count_q   <= '0;
            bit_index_q   <= '0;
            tx_byte_q     <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            clk_count_q   <= clk_count_d;
            bit_index_q   <= bit_index_d;
            tx_byte_q     <= tx_byte_d;
            frame_count_q <= frame_count_d;
        end
    end
    always_comb begin
        state_d       = state_q;
        clk_count_d   = bit_end ? '0 : clk_count_q + 12'd1;
        bit_index_d   = bit_index_q;
        tx_byte_d     = tx_byte_q;
        frame_count_d = frame_count_q;
        case (state_q)
            s_IDLE: begin
                clk_count_d = '0;
                if (i_Tx_DV) begin
                    tx_byte_d   = i_Tx_Byte;
                    bit_index_d = '0;
                    state_d     = s_TX_START_BIT;
                end
            end
            s_TX_START_BIT: state_d = bit_end ? s_TX_DATA_BITS : s_TX_START_BIT;
            s_TX_DATA_BITS: begin
                // bit_index wraps 7 -> 0 on its own, leaving it cleared for STOP
                if (bit_end) begin
                    bit_index_d = bit_index_q + 3'd1;
                    state_d     = bit_index_q == 3'd7 ? s_TX_STOP_BIT : s_TX_DATA_BITS;
                end
            end
            s_TX_STOP_BIT: state_d = bit_end ? s_CLEANUP : s_TX_STOP_BIT;
            s_CLEANUP: begin
                clk_count_d   = '0;
                frame_count_d = frame_count_q + 8'd1;
                state_d       = s_IDLE;
            end
            default: begin
                clk_count_d = '0;
                bit_index_d = '0;
                state_d     = s_IDLE;
            end
        endcase
    end
    assign current_state = state_q;
    assign bit_index     = bit_index_q;
    assign o_Tx_Byte     = tx_byte_q;
    assign o_Frame_Count = frame_count_q;
    assign o_Tx_Ready    = state_q == s_IDLE;
    assign o_Tx_Done     = state_q == s_CLEANUP;
    assign o_Tx_Active   = state_q == s_TX_START_BIT || state_q == s_TX_DATA_BITS || state_q == s_TX_STOP_BIT;
    assign o_Tx_Serial   = state_q == s_TX_START_BIT ? 1'b0 :
                           state_q == s_TX_DATA_BITS ? tx_byte_q[bit_index_q] : 1'b1;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: randomized self-checking bench for uart_tx_ctrl against a bit-time waveform model
module tb_uart_tx_ctrl;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready, serial, active, done;
    logic [2:0] state, bidx;
    logic [7:0] obyte, fcount;
    int         checks = 0;
    int         fails = 0;
    int         done_pulses = 0;
    logic       prev_done = 1'b0;
    logic [7:0] exp_frames = 8'd0;
    uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(din),
        .o_Tx_Ready(ready), .current_state(state), .bit_index(bidx), .o_Tx_Byte(obyte),
        .o_Tx_Serial(serial), .o_Tx_Active(active), .o_Tx_Done(done), .o_Frame_Count(fcount)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            checks += 4;
            if (ready !== (state == 3'd0)) begin
                fails++; $display("FAIL inv_ready: ready=%b state=%0d", ready, state);
            end
            if (state != 3'd1 && state != 3'd2 && serial !== 1'b1) begin
                fails++; $display("FAIL inv_serial: serial=%b state=%0d, required 1", serial, state);
            end
            if (state != 3'd2 && bidx !== 3'd0) begin
                fails++; $display("FAIL inv_bidx: bit_index=%0d state=%0d, required 0", bidx, state);
            end
            if (done && prev_done) begin
                fails++; $display("FAIL inv_done_width: done high two cycles in a row");
            end
            if (done) done_pulses++;
            prev_done = done;
        end else prev_done = 1'b0;
    endtask
    task automatic start(input logic [7:0] b);
        dv = 1'b1;
        din = b;
        @(posedge clk);
    endtask
    task automatic check_frame(input logic [7:0] b, input bit hold, input logic [7:0] next_b,
                               input int busy_at, input bit noise);
        int pos;
        logic exp_line;
        logic [2:0] exp_state, exp_bidx;
        for (int c = 1; c <= FRAME + 2; c++) begin
            tick();
            pos = (c - 1) / CPB;
            if (c <= FRAME) begin
                exp_state = pos == 0 ? 3'd1 : pos <= 8 ? 3'd2 : 3'd3;
                exp_line  = pos == 0 ? 1'b0 : pos <= 8 ? b[pos-1] : 1'b1;
                exp_bidx  = (pos >= 1 && pos <= 8) ? 3'(pos - 1) : 3'd0;
            end else begin
                exp_state = c == FRAME + 1 ? 3'd4 : 3'd0;
                exp_line  = 1'b1;
                exp_bidx  = 3'd0;
            end
            checks++;
            if (serial !== exp_line || state !== exp_state || bidx !== exp_bidx) begin
                fails++;
                $display("FAIL frame_%02h cycle %0d: serial=%b state=%0d bidx=%0d, required serial=%b state=%0d bidx=%0d",
                         b, c, serial, state, bidx, exp_line, exp_state, exp_bidx);
            end
            checks++;
            if (done !== (c == FRAME + 1) || active !== (c <= FRAME)) begin
                fails++;
                $display("FAIL flags_%02h cycle %0d: done=%b active=%b, required done=%b active=%b",
                         b, c, done, active, c == FRAME + 1, c <= FRAME);
            end
            if (c == FRAME + 1) begin
                checks++;
                if (fcount !== exp_frames) begin
                    fails++; $display("FAIL count_in_cleanup: %0d, required %0d", fcount, exp_frames);
                end
                exp_frames++;
            end
            if (c == FRAME + 2) begin
                checks++;
                if (fcount !== exp_frames || obyte !== b) begin
                    fails++;
                    $display("FAIL count_after: count=%0d byte=%02h, required count=%0d byte=%02h", fcount, obyte, exp_frames, b);
                end
            end
            if (hold) begin
                if (c == 1) din = next_b;
            end else begin
                dv  = c == busy_at;
                din = c == busy_at ? 8'hFF : noise ? 8'($urandom) : din;
            end
        end
    endtask
    task automatic test_reset();
        #3;
        checks++;
        if ({state, bidx, obyte, fcount, serial, ready, active, done} !== {3'd0, 3'd0, 8'd0, 8'd0, 4'b1100}) begin
            fails++; $display("FAIL reset_values: state=%0d bidx=%0d byte=%02h count=%0d serial=%b ready=%b active=%b done=%b",
                              state, bidx, obyte, fcount, serial, ready, active, done);
        end
        dv = 1'b1; din = 8'h5A;
        repeat (3) tick();
        checks++;
        if (state !== 3'd0 || obyte !== 8'd0 || serial !== 1'b1) begin
            fails++; $display("FAIL reset_hold: state=%0d byte=%02h serial=%b, required 0/00/1", state, obyte, serial);
        end
        dv = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
    endtask
    task automatic test_single();
        start(8'hA5);
        check_frame(8'hA5, 1'b0, 8'h00, 0, 1'b0);
    endtask
    task automatic test_busy();
        start(8'h3C);
        check_frame(8'h3C, 1'b0, 8'h00, 20, 1'b0);
        repeat (CPB * 3) tick();
        checks++;
        if (state !== 3'd0 || fcount !== exp_frames) begin
            fails++; $display("FAIL busy_ignore: state=%0d count=%0d, required 0/%0d", state, fcount, exp_frames);
        end
    endtask
    task automatic test_random();
        logic [7:0] b;
        repeat (6) begin
            repeat ($urandom_range(0, 3)) tick();
            b = 8'($urandom);
            start(b);
            check_frame(b, 1'b0, 8'h00, int'($urandom_range(1, 40)), 1'b1);
        end
    endtask
    task automatic test_back_to_back();
        start(8'h00);
        check_frame(8'h00, 1'b1, 8'hFF, 0, 1'b0);
        @(posedge clk);
        check_frame(8'hFF, 1'b0, 8'h00, 0, 1'b0);
    endtask
    task automatic test_reset_mid_frame();
        int pulses;
        logic [7:0] b;
        b = 8'($urandom);
        pulses = done_pulses;
        start(b);
        dv = 1'b0;
        repeat (15) tick();
        #2 rst_n = 1'b0;
        #1;
        exp_frames = 8'd0;
        checks++;
        if (serial !== 1'b1 || state !== 3'd0 || ready !== 1'b1 || active !== 1'b0 || done !== 1'b0 ||
            fcount !== 8'd0 || obyte !== 8'd0 || bidx !== 3'd0) begin
            fails++; $display("FAIL async_abort: serial=%b state=%0d ready=%b active=%b done=%b count=%0d byte=%02h bidx=%0d",
                              serial, state, ready, active, done, fcount, obyte, bidx);
        end
        dv = 1'b1;
        repeat (2) tick();
        dv = 1'b0;
        rst_n = 1'b1;
        checks++;
        if (done_pulses !== pulses) begin
            fails++; $display("FAIL abort_no_done: pulses=%0d, required %0d", done_pulses, pulses);
        end
        start(8'h81);
        check_frame(8'h81, 1'b0, 8'h00, 0, 1'b0);
    endtask
    task automatic test_wrap();
        int pulses;
        logic [7:0] b;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_frames = 8'd0;
        pulses = done_pulses;
        repeat (256) begin
            b = 8'($urandom);
            start(b);
            check_frame(b, 1'b0, 8'h00, 0, 1'b1);
        end
        checks++;
        if (fcount !== 8'd0 || done_pulses - pulses !== 256) begin
            fails++; $display("FAIL wrap: count=%0d pulses=%0d, required 0/256", fcount, done_pulses - pulses);
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_busy();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
